// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4 INCR burst slave onto an asynchronous 32-bit SRAM.
// Define AXI_SRAM_WSTRB_EN to honour w_strb as SRAM byte enables.
module axi_sram_slave (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  io_axi_ar_id,
   input  logic [31:0] io_axi_ar_addr,
   input  logic [7:0]  io_axi_ar_len,
   input  logic        io_axi_ar_valid,
   output logic        io_axi_ar_ready,
   output logic [7:0]  io_axi_r_id,
   output logic [31:0] io_axi_r_data,
   output logic [1:0]  io_axi_r_resp,
   output logic        io_axi_r_last,
   output logic        io_axi_r_valid,
   input  logic        io_axi_r_ready,
   input  logic [7:0]  io_axi_aw_id,
   input  logic [31:0] io_axi_aw_addr,
   input  logic [7:0]  io_axi_aw_len,
   input  logic        io_axi_aw_valid,
   output logic        io_axi_aw_ready,
   input  logic [31:0] io_axi_w_data,
   input  logic [3:0]  io_axi_w_strb,
   input  logic        io_axi_w_last,
   input  logic        io_axi_w_valid,
   output logic        io_axi_w_ready,
   output logic [7:0]  io_axi_b_id,
   output logic [1:0]  io_axi_b_resp,
   output logic        io_axi_b_valid,
   input  logic        io_axi_b_ready,
   inout  wire  [31:0] ram_data,
   output logic [19:0] ram_addr,
   output logic [3:0]  ram_be_n,
   output logic        ram_ce_n,
   output logic        ram_oe_n,
   output logic        ram_we_n
);

   typedef enum logic [2:0] {
      IDLE,
      RD_ADDR,
      RD_DATA,
      WR_DATA,
      WR_RESP
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic [19:0] addr;
   logic [7:0]  len;
   logic [7:0]  cnt;
   logic        beat_last;
   logic        ram_drive;

   // Beat count reaching len marks the final beat; w_last is not trusted.
   assign beat_last = (cnt == len);

   assign io_axi_r_resp = 2'b00;
   assign io_axi_b_resp = 2'b00;
   assign ram_addr      = addr;
   assign ram_data      = ram_drive ? io_axi_w_data : 32'bz;

`ifndef AXI_SRAM_WSTRB_EN
   logic unused_strb;
   assign unused_strb = ^io_axi_w_strb;
`endif
   logic unused_in;
   assign unused_in = ^{io_axi_w_last,
                        io_axi_ar_addr[31:22], io_axi_ar_addr[1:0],
                        io_axi_aw_addr[31:22], io_axi_aw_addr[1:0]};

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next state, handshake outputs and SRAM strobes.
   always_comb begin
      state_nx        = state;
      io_axi_ar_ready = 1'b0;
      io_axi_aw_ready = 1'b0;
      io_axi_w_ready  = 1'b0;
      io_axi_r_valid  = 1'b0;
      io_axi_r_last   = 1'b0;
      io_axi_b_valid  = 1'b0;
      ram_ce_n        = 1'b1;
      ram_oe_n        = 1'b1;
      ram_we_n        = 1'b1;
      ram_be_n        = 4'hF;
      ram_drive       = 1'b0;
      unique case (state)
         IDLE: begin
            // Writes take priority when both address channels are valid.
            io_axi_aw_ready = rst_n;
            io_axi_ar_ready = rst_n & ~io_axi_aw_valid;
            if (io_axi_aw_valid)      state_nx = WR_DATA;
            else if (io_axi_ar_valid) state_nx = RD_ADDR;
         end
         RD_ADDR: begin
            ram_ce_n = 1'b0;
            ram_oe_n = 1'b0;
            ram_be_n = 4'h0;
            state_nx = RD_DATA;
         end
         RD_DATA: begin
            io_axi_r_valid = 1'b1;
            io_axi_r_last  = beat_last;
            if (io_axi_r_ready) state_nx = beat_last ? IDLE : RD_ADDR;
         end
         WR_DATA: begin
            io_axi_w_ready = 1'b1;
            if (io_axi_w_valid) begin
               ram_ce_n  = 1'b0;
               ram_we_n  = 1'b0;
               ram_drive = 1'b1;
`ifdef AXI_SRAM_WSTRB_EN
               ram_be_n  = ~io_axi_w_strb;
`else
               ram_be_n  = 4'h0;
`endif
               if (beat_last) state_nx = WR_RESP;
            end
         end
         WR_RESP: begin
            io_axi_b_valid = 1'b1;
            if (io_axi_b_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Burst bookkeeping, echoed IDs and captured read data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr          <= '0;
         len           <= '0;
         cnt           <= '0;
         io_axi_r_id   <= '0;
         io_axi_b_id   <= '0;
         io_axi_r_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (io_axi_aw_valid) begin
                  io_axi_b_id <= io_axi_aw_id;
                  addr        <= io_axi_aw_addr[21:2];
                  len         <= io_axi_aw_len;
                  cnt         <= '0;
               end else if (io_axi_ar_valid) begin
                  io_axi_r_id <= io_axi_ar_id;
                  addr        <= io_axi_ar_addr[21:2];
                  len         <= io_axi_ar_len;
                  cnt         <= '0;
               end
            end
            RD_ADDR: io_axi_r_data <= ram_data;
            RD_DATA: begin
               if (io_axi_r_ready && !beat_last) begin
                  addr <= addr + 20'd1;
                  cnt  <= cnt + 8'd1;
               end
            end
            WR_DATA: begin
               if (io_axi_w_valid) begin
                  addr <= addr + 20'd1;
                  cnt  <= cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: scoreboard bench for axi_sram_slave with an SRAM
// model and a word-level reference memory.
module tb_axi_sram_slave;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  ar_id, aw_id;
   logic [31:0] ar_addr, aw_addr;
   logic [7:0]  ar_len, aw_len;
   logic        ar_valid, aw_valid;
   logic        ar_ready, aw_ready;
   logic [7:0]  r_id, b_id;
   logic [31:0] r_data;
   logic [1:0]  r_resp, b_resp;
   logic        r_last, r_valid, r_ready;
   logic [31:0] w_data;
   logic [3:0]  w_strb;
   logic        w_last, w_valid, w_ready;
   logic        b_valid, b_ready;
   wire  [31:0] ram_data;
   logic [19:0] ram_addr;
   logic [3:0]  ram_be_n;
   logic        ram_ce_n, ram_oe_n, ram_we_n;

   int errors = 0;
   int checks = 0;
   logic hold_r = 1'b0;

   typedef struct packed {
      logic [7:0]  id;
      logic [31:0] data;
      logic        last;
   } rexp_t;

   typedef struct packed {
      logic [19:0] addr;
      logic [31:0] data;
      logic [3:0]  be_n;
   } wexp_t;

   rexp_t       r_q[$];
   logic [7:0]  b_q[$];
   logic [19:0] ra_q[$];
   wexp_t       wa_q[$];

   logic [31:0] sram [0:1048575];
   logic [31:0] ref_mem [logic [19:0]];
   logic [31:0] wd [0:255];
   logic [3:0]  ws [0:255];

   always #10 clk = ~clk;

   axi_sram_slave dut (
      .clk(clk), .rst_n(rst_n),
      .io_axi_ar_id(ar_id), .io_axi_ar_addr(ar_addr),
      .io_axi_ar_len(ar_len), .io_axi_ar_valid(ar_valid),
      .io_axi_ar_ready(ar_ready),
      .io_axi_r_id(r_id), .io_axi_r_data(r_data),
      .io_axi_r_resp(r_resp), .io_axi_r_last(r_last),
      .io_axi_r_valid(r_valid), .io_axi_r_ready(r_ready),
      .io_axi_aw_id(aw_id), .io_axi_aw_addr(aw_addr),
      .io_axi_aw_len(aw_len), .io_axi_aw_valid(aw_valid),
      .io_axi_aw_ready(aw_ready),
      .io_axi_w_data(w_data), .io_axi_w_strb(w_strb),
      .io_axi_w_last(w_last), .io_axi_w_valid(w_valid),
      .io_axi_w_ready(w_ready),
      .io_axi_b_id(b_id), .io_axi_b_resp(b_resp),
      .io_axi_b_valid(b_valid), .io_axi_b_ready(b_ready),
      .ram_data(ram_data), .ram_addr(ram_addr),
      .ram_be_n(ram_be_n), .ram_ce_n(ram_ce_n),
      .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n)
   );

   // Asynchronous SRAM: drives the bus on output-enabled reads.
   assign ram_data = (!ram_ce_n && !ram_oe_n && ram_we_n)
                     ? sram[ram_addr] : 32'bz;

   // SRAM write with active-low byte enables.
   always @(posedge clk) begin
      if (rst_n && !ram_ce_n && !ram_we_n)
         for (int b = 0; b < 4; b++)
            if (!ram_be_n[b])
               sram[ram_addr][8*b +: 8] <= ram_data[8*b +: 8];
   end

   function automatic logic [31:0] init_word(input logic [19:0] a);
      return {12'hC5A, a};
   endfunction

   function automatic logic [31:0] ref_rd(input logic [19:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return init_word(a);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Monitor: pop and compare whenever the DUT presents a transfer.
   initial begin
      rexp_t re;
      wexp_t we;
      logic [7:0] bi;
      logic [19:0] ra;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (r_valid && r_ready) begin
               if (r_q.size() == 0) chk("r_unexpected", 1, 0);
               else begin
                  re = r_q.pop_front();
                  chk("r_id", r_id, re.id);
                  chk("r_data", r_data, re.data);
                  chk("r_last", r_last, re.last);
                  chk("r_resp", r_resp, 0);
               end
            end
            if (b_valid && b_ready) begin
               if (b_q.size() == 0) chk("b_unexpected", 1, 0);
               else begin
                  bi = b_q.pop_front();
                  chk("b_id", b_id, bi);
                  chk("b_resp", b_resp, 0);
               end
            end
            if (!ram_ce_n && !ram_oe_n) begin
               if (ra_q.size() == 0) chk("ram_rd_unexpected", 1, 0);
               else begin
                  ra = ra_q.pop_front();
                  chk("ram_rd_addr", ram_addr, ra);
                  chk("ram_rd_be_n", ram_be_n, 0);
                  chk("ram_rd_we_n", ram_we_n, 1);
               end
            end
            if (!ram_ce_n && !ram_we_n) begin
               if (wa_q.size() == 0) chk("ram_wr_unexpected", 1, 0);
               else begin
                  we = wa_q.pop_front();
                  chk("ram_wr_addr", ram_addr, we.addr);
                  chk("ram_wr_data", ram_data, we.data);
                  chk("ram_wr_be_n", ram_be_n, we.be_n);
                  chk("ram_wr_oe_n", ram_oe_n, 1);
               end
            end
         end
      end
   end

   // Random master-side ready, forced low while hold_r is set.
   initial begin
      r_ready = 1'b0;
      b_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         r_ready = hold_r ? 1'b0 : ($urandom_range(0, 3) != 0);
         b_ready = ($urandom_range(0, 2) != 0);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got time limit want completion");
      $fatal(1, "watchdog");
   end

   task automatic wait_hs(input int sel, input string nm, input bit adv);
      int n = 0;
      forever begin
         @(negedge clk);
         if ((sel == 0 && ar_ready) || (sel == 1 && aw_ready) ||
             (sel == 2 && w_ready) || (sel == 3 && r_valid)) break;
         n++;
         if (n > 3000) begin
            chk({"timeout_", nm}, 1, 0);
            break;
         end
      end
      if (adv) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic prep_read(input logic [7:0] id, input logic [31:0] a,
                            input logic [7:0] len);
      logic [19:0] w;
      rexp_t e;
      for (int i = 0; i <= int'(len); i++) begin
         w = a[21:2] + 20'(i);
         e.id   = id;
         e.data = ref_rd(w);
         e.last = (i == int'(len));
         r_q.push_back(e);
         ra_q.push_back(w);
      end
   endtask

   task automatic prep_write(input logic [7:0] id, input logic [31:0] a,
                             input logic [7:0] len, input int mode);
      logic [19:0] w;
      logic [31:0] d;
      logic [3:0]  s;
      wexp_t e;
      for (int i = 0; i <= int'(len); i++) begin
         w = a[21:2] + 20'(i);
         d = $urandom;
         s = 4'($urandom_range(0, 15));
         if (mode == 1) begin
            d = 32'(i + 1);
            s = 4'hF;
         end else if (mode == 2) begin
            s = 4'b0010;
         end
         wd[i] = d;
         ws[i] = s;
         e.addr = w;
         e.data = d;
`ifdef AXI_SRAM_WSTRB_EN
         e.be_n = ~s;
         begin
            logic [31:0] m;
            m = ref_rd(w);
            for (int b = 0; b < 4; b++)
               if (s[b]) m[8*b +: 8] = d[8*b +: 8];
            ref_mem[w] = m;
         end
`else
         e.be_n = 4'h0;
         ref_mem[w] = d;
`endif
         wa_q.push_back(e);
      end
      b_q.push_back(id);
   endtask

   task automatic send_w(input logic [7:0] len);
      for (int i = 0; i <= int'(len); i++) begin
         if ($urandom_range(0, 3) == 0) begin
            w_valid = 1'b0;
            @(posedge clk); #1;
         end
         w_data  = wd[i];
         w_strb  = ws[i];
         w_last  = (i == int'(len));
         w_valid = 1'b1;
         wait_hs(2, "w", 1);
         w_valid = 1'b0;
         w_last  = 1'b0;
      end
   endtask

   task automatic do_read(input logic [7:0] id, input logic [31:0] a,
                          input logic [7:0] len);
      prep_read(id, a, len);
      ar_id = id; ar_addr = a; ar_len = len; ar_valid = 1'b1;
      wait_hs(0, "ar", 1);
      ar_valid = 1'b0;
   endtask

   task automatic do_write(input logic [7:0] id, input logic [31:0] a,
                           input logic [7:0] len, input int mode);
      prep_write(id, a, len, mode);
      aw_id = id; aw_addr = a; aw_len = len; aw_valid = 1'b1;
      wait_hs(1, "aw", 1);
      aw_valid = 1'b0;
      send_w(len);
   endtask

   task automatic clear_q();
      r_q.delete(); b_q.delete(); ra_q.delete(); wa_q.delete();
   endtask

   task automatic drain();
      int n = 0;
      while (r_q.size() + b_q.size() + ra_q.size() + wa_q.size() != 0) begin
         @(negedge clk);
         n++;
         if (n > 5000) begin
            chk("timeout_drain", 1, 0);
            clear_q();
            break;
         end
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic check_reset(input string t);
      chk({t, "_ar_ready"}, ar_ready, 0);
      chk({t, "_aw_ready"}, aw_ready, 0);
      chk({t, "_w_ready"}, w_ready, 0);
      chk({t, "_r_valid"}, r_valid, 0);
      chk({t, "_b_valid"}, b_valid, 0);
      chk({t, "_r_data"}, r_data, 0);
      chk({t, "_r_id"}, r_id, 0);
      chk({t, "_b_id"}, b_id, 0);
      chk({t, "_ram_addr"}, ram_addr, 0);
      chk({t, "_ram_ce_n"}, ram_ce_n, 1);
      chk({t, "_ram_oe_n"}, ram_oe_n, 1);
      chk({t, "_ram_we_n"}, ram_we_n, 1);
      chk({t, "_ram_be_n"}, ram_be_n, 4'hF);
   endtask

   initial begin
      logic [31:0] bp_d;
      logic [19:0] bp_a;
      logic [31:0] ra;
      rst_n = 1'b0;
      ar_id = 0; ar_addr = 0; ar_len = 0; ar_valid = 0;
      aw_id = 0; aw_addr = 0; aw_len = 0; aw_valid = 0;
      w_data = 0; w_strb = 0; w_last = 0; w_valid = 0;
      for (int i = 0; i < 1048576; i++) sram[i] = init_word(20'(i));
      sram[4]    = 32'hDEADBEEF;
      ref_mem[4] = 32'hDEADBEEF;

      repeat (2) @(negedge clk);
      check_reset("rst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_ar_ready", ar_ready, 1);
      chk("idle_aw_ready", aw_ready, 1);
      @(posedge clk); #1;

      // Single read of word 4.
      do_read(8'h05, 32'h80000010, 8'd0);
      drain();

      // Four-beat write of 1..4, then read back.
      do_write(8'h3C, 32'h80000000, 8'd3, 1);
      drain();
      for (int i = 0; i < 4; i++)
         chk("sram_seq_word", sram[i], 32'(i + 1));
      do_read(8'h3D, 32'h80000000, 8'd3);
      drain();

      // Word address wrap at the top of the 20-bit space.
      do_read(8'h11, 32'h003FFFF8, 8'd2);
      do_write(8'h12, 32'h003FFFFC, 8'd1, 0);
      drain();

      // Backpressure on the first beat of a two-beat read.
      hold_r = 1'b1;
      do_read(8'h21, 32'h00000040, 8'd1);
      wait_hs(3, "bp_r_valid", 0);
      bp_d = r_data;
      bp_a = ram_addr;
      chk("bp_data_ref", bp_d, ref_rd(20'd16));
      repeat (5) begin
         @(negedge clk);
         chk("bp_r_valid", r_valid, 1);
         chk("bp_r_data", r_data, bp_d);
         chk("bp_r_last", r_last, 0);
         chk("bp_ram_addr", ram_addr, bp_a);
         chk("bp_ram_oe_n", ram_oe_n, 1);
      end
      @(posedge clk); #1;
      hold_r = 1'b0;
      drain();

      // Both address channels valid together: write goes first.
      prep_write(8'h31, 32'h00000080, 8'd1, 2);
      prep_read(8'h32, 32'h00000080, 8'd1);
      aw_id = 8'h31; aw_addr = 32'h00000080; aw_len = 8'd1;
      ar_id = 8'h32; ar_addr = 32'h00000080; ar_len = 8'd1;
      aw_valid = 1'b1;
      ar_valid = 1'b1;
      @(negedge clk);
      chk("simul_ar_ready", ar_ready, 0);
      chk("simul_aw_ready", aw_ready, 1);
      @(posedge clk); #1;
      aw_valid = 1'b0;
      send_w(8'd1);
      wait_hs(0, "ar_simul", 1);
      ar_valid = 1'b0;
      drain();

      // Reset in the middle of a read burst.
      hold_r = 1'b1;
      do_read(8'h44, 32'h00000100, 8'd5);
      wait_hs(3, "r_valid_rst", 0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      check_reset("midrst");
      clear_q();
      @(posedge clk); #1;
      rst_n  = 1'b1;
      hold_r = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_r_valid", r_valid, 0);
         chk("post_rst_b_valid", b_valid, 0);
      end
      chk("post_rst_ar_ready", ar_ready, 1);
      @(posedge clk); #1;
      do_read(8'h45, 32'h00000100, 8'd0);
      drain();

      // Randomised mix of bursts over a small window.
      repeat (40) begin
         ra = ($urandom & 32'hFFC00003) |
              (32'($urandom_range(0, 63)) << 2);
         if ($urandom_range(0, 1) == 1)
            do_write(8'($urandom), ra, 8'($urandom_range(0, 7)), 0);
         else
            do_read(8'($urandom), ra, 8'($urandom_range(0, 7)));
      end
      drain();
      chk("queues_empty",
          r_q.size() + b_q.size() + ra_q.size() + wa_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock (50 MHz); all logic on its rising edge.
REQ-002 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port io_axi_ar_id, input, 8 bits: read burst ID.
REQ-004 The block SHALL have port io_axi_ar_addr, input, 32 bits: read byte address; bits [21:2] form the SRAM word address.
REQ-005 The block SHALL have port io_axi_ar_len, input, 8 bits: read beats minus 1.
REQ-006 The block SHALL have port io_axi_ar_valid, input, 1 bit: read address valid.
REQ-007 The block SHALL have port io_axi_ar_ready, output, 1 bit: read address accepted.
REQ-008 The block SHALL have port io_axi_r_id, output, 8 bits: echo of the latched ar_id.
REQ-009 The block SHALL have port io_axi_r_data, output, 32 bits: read beat data.
REQ-010 The block SHALL have port io_axi_r_resp, output, 2 bits: constant 2'b00 (OKAY).
REQ-011 The block SHALL have port io_axi_r_last, output, 1 bit: final read beat.
REQ-012 The block SHALL have port io_axi_r_valid, output, 1 bit: read beat valid.
REQ-013 The block SHALL have port io_axi_r_ready, input, 1 bit: master accepts read beat.
REQ-014 The block SHALL have port io_axi_aw_id, input, 8 bits: write burst ID.
REQ-015 The block SHALL have port io_axi_aw_addr, input, 32 bits: write byte address; bits [21:2] form the SRAM word address.
REQ-016 The block SHALL have port io_axi_aw_len, input, 8 bits: write beats minus 1.
REQ-017 The block SHALL have port io_axi_aw_valid, input, 1 bit: write address valid.
REQ-018 The block SHALL have port io_axi_aw_ready, output, 1 bit: write address accepted.
REQ-019 The block SHALL have port io_axi_w_data, input, 32 bits: write beat data.
REQ-020 The block SHALL have port io_axi_w_strb, input, 4 bits: byte strobes.
REQ-021 The block SHALL have port io_axi_w_last, input, 1 bit: final write beat; ignored, the beat count governs.
REQ-022 The block SHALL have port io_axi_w_valid, input, 1 bit: write beat valid.
REQ-023 The block SHALL have port io_axi_w_ready, output, 1 bit: write beat accepted.
REQ-024 The block SHALL have port io_axi_b_id, output, 8 bits: echo of the latched aw_id.
REQ-025 The block SHALL have port io_axi_b_resp, output, 2 bits: constant 2'b00.
REQ-026 The block SHALL have port io_axi_b_valid, output, 1 bit: write response valid.
REQ-027 The block SHALL have port io_axi_b_ready, input, 1 bit: master accepts write response.
REQ-028 The block SHALL have port ram_data, inout, 32 bits: SRAM data bus; driven only during writes, high-Z otherwise.
REQ-029 The block SHALL have port ram_addr, output, 20 bits: SRAM word address.
REQ-030 The block SHALL have port ram_be_n, output, 4 bits: SRAM byte enables, active low.
REQ-031 The block SHALL have port ram_ce_n, output, 1 bit: SRAM chip select, active low.
REQ-032 The block SHALL have port ram_oe_n, output, 1 bit: SRAM output enable, active low.
REQ-033 The block SHALL have port ram_we_n, output, 1 bit: SRAM write enable, active low.

Function
REQ-034 The block SHALL implement states IDLE, RD_ADDR, RD_DATA, WR_DATA, WR_RESP; only INCR, 4-byte beats are supported, and no size/burst inputs exist.
REQ-035 In IDLE the block SHALL assert ar_ready and aw_ready; if aw_valid and ar_valid are both high in the same cycle, the write SHALL win and ar_ready SHALL drop that cycle.
REQ-036 On an ar handshake the block SHALL latch id, addr[21:2] and len, then go to RD_ADDR, where it drives ram_ce_n=0, ram_oe_n=0, ram_be_n=0 and ram_addr for exactly one cycle.
REQ-037 In RD_ADDR the block SHALL capture ram_data into r_data at the next clock edge and enter RD_DATA with r_valid=1.
REQ-038 In RD_DATA the block SHALL hold r_valid, r_data and r_last stable until r_ready; on the handshake it SHALL increment the word address (20-bit wrap from 0xFFFFF to 0x00000) and return to RD_ADDR, or go to IDLE after the beat with r_last=1 (beat count == len). Each beat therefore takes a minimum of 2 cycles.
REQ-039 On an aw handshake the block SHALL latch id, addr and len and go to WR_DATA, where w_ready=1.
REQ-040 On each w handshake the block SHALL drive ram_we_n=0, ram_ce_n=0 and ram_data=w_data in that same cycle, then increment the address; after beat len it SHALL go to WR_RESP.
REQ-041 In WR_RESP the block SHALL hold b_valid=1 until b_ready, then return to IDLE.
REQ-042 Outside active access cycles the block SHALL hold ram_ce_n, ram_oe_n and ram_we_n at 1 and keep ram_data at high-Z.

Reset
REQ-043 While rst_n=0 the block SHALL be in IDLE, with all valid/ready outputs at 0, r_data/r_id/b_id=0, ram_addr=0, ram_ce_n/oe_n/we_n/be_n all 1 and ram_data at high-Z; a reset mid-burst SHALL abandon the burst with no response issued.

Configuration
REQ-044 With AXI_SRAM_WSTRB_EN defined, writes SHALL drive ram_be_n=~w_strb; without it, ram_be_n SHALL be 4'b0000 on writes (full-word writes only).

Verification
REQ-045 Single read: ar addr=0x80000010, len=0, id=0x05, SRAM word 4 holds 0xDEADBEEF -> r_data=0xDEADBEEF, r_id=0x05, r_last=1, ram_addr=0x00004.
REQ-046 4-beat write: aw addr=0x80000000, len=3, w_data 1..4 -> SRAM words 0..3 contain 1..4 and exactly one b_valid with the echoed id.
REQ-047 Backpressure: read len=1 with r_ready held low 5 cycles -> r_data/r_valid stable throughout and no address advance.
REQ-048 Simultaneous ar_valid and aw_valid in IDLE -> the write completes first, then the read is accepted; with WSTRB_EN and w_strb=4'b0010 -> ram_be_n=4'b1101; rst_n pulsed mid-burst -> IDLE and outputs at reset values.
